branch_feedback_queue: RTL and testbench
========================================

# branch_feedback_queue

In-order queue holding per-branch prediction metadata from decode until ROB commit. It sits between the decoder/branch_controller and the tournament predictor, and is the producer of the predictor's feedback port. Each branch is allocated at decode and resolved out of order by tag from execute; an early redirect is issued on a mispredict. At commit it emits registered feedback (pc, ghistory, all three predictions, outcome) in program order.

## Interface
- DEPTH, 8: entries; power of two, ≥2.
- TAG_W, $clog2(DEPTH): tag width.

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- i_alloc_valid  in  1  decoded branch to enqueue
- i_alloc_entry  in  branch_pred_storage  prediction metadata from branch_controller
- o_alloc_ready  out  1  queue not full
- o_alloc_tag  out  TAG_W  tag assigned to the current allocation (tail index)
- i_resolve_valid  in  1  execute resolved a branch
- i_resolve_tag  in  TAG_W  tag of the resolved branch
- i_resolve_outcome  in  BranchOutcome  actual direction
- o_redirect_valid  out  1  mispredict pulse
- o_redirect_target  out  ADDR_WIDTH  fetch redirect address
- o_redirect_tag  out  TAG_W  mispredicted tag
- i_commit_valid  in  1  ROB commits the oldest branch
- o_commit_ready  out  1  head valid and resolved
- i_flush  in  1  full squash (exception)
- o_fb_valid  out  1  feedback pulse to predictor
- o_fb_entry  out  branch_pred_storage  committed metadata
- o_fb_outcome  out  BranchOutcome  committed outcome
- o_count  out  TAG_W+1  occupied entries
- o_empty  out  1  o_count == 0

## Operation
- Circular buffer. Head and tail pointers are TAG_W+1 bits wide; the extra bit is a wrap bit.
  - full = indices equal and wrap bits differ; empty = pointers equal.
- Per-entry state: valid, resolved, outcome, branch_pred_storage.
- Alloc: fires when i_alloc_valid && o_alloc_ready. Writes the entry at the tail, clears resolved, and increments tail.
- Resolve: acts only if the tag's entry is valid and unresolved; otherwise the event is ignored.
  - Sets resolved and stores the outcome.
  - If outcome ≠ entry.prediction: raise the redirect with target = entry.recovery_target, and set tail = tag+1, squashing all younger entries.
- Commit: fires when i_commit_valid && o_commit_ready. Pops the head and registers the entry and outcome onto o_fb_*.
  - i_commit_valid while not ready is a protocol violation. It is ignored, and under an assertion it is flagged.
- i_flush: clears all entries, sets head = tail = 0, and drops any same-cycle alloc, resolve or commit.
  - o_fb_valid and o_redirect_valid are 0 the following cycle.
- Simultaneous events:
  - Mispredicting resolve + alloc in the same cycle: the alloc is dropped (wrong path).
  - Resolve + commit in the same cycle: both act (distinct entries).
  - Alloc + commit when full: no alloc, because ready reflects pre-edge occupancy.

## Timing
- Reset values: o_alloc_ready=1, o_alloc_tag=0, o_redirect_valid=0, o_redirect_target=0, o_redirect_tag=0, o_commit_ready=0, o_fb_valid=0, o_fb_entry='0, o_fb_outcome=NOT_TAKEN, o_count=0, o_empty=1. All entries are invalid.
- o_alloc_ready, o_alloc_tag, o_commit_ready, o_count and o_empty are combinational from state.
- Alloc/resolve/commit state updates at the edge ending cycle N.
- o_redirect_* are registered: a one-cycle pulse in cycle N+1.
- o_fb_* are registered: a one-cycle pulse in cycle N+1.
- Earliest commit of an entry is the cycle after its resolve.
- Reset asserted mid-operation returns every output and all state to reset values asynchronously.

## Configuration
- BRANCH_FB_STATS_EN defined: four 32-bit saturating counters, updated on each o_fb_valid pulse.
  - commits
  - mispredicts (prediction ≠ outcome)
  - gshare_correct
  - twobit_correct
  - All four are zeroed by rst, exposed as outputs o_stat_*, and not cleared by i_flush.
- BRANCH_FB_STATS_EN undefined: the counters and o_stat_* ports are absent. Behaviour is otherwise identical.

## Structure
- mips_core_pkg:
  - add BFQ_DEPTH (default 8) and typedef bfq_tag_t.
  - branch_pred_storage and BranchOutcome are reused unchanged.
- Sub-module branch_fb_stats: counters only, instantiated under BRANCH_FB_STATS_EN.

## Test plan
- **Fill and backpressure:** alloc 8 branches (pc 0x100..0x11C).
  - Tags returned are 0..7.
  - o_alloc_ready=0 and o_count=8.
  - A 9th alloc is ignored.
- **In-order feedback:** resolve tags 2,0,1 correctly, then commit ×3.
  - o_fb_valid pulses carry pcs 0x100, 0x104, 0x108 in order.
  - Each pulse arrives one cycle after its commit.
- **Mispredict squash:** 5 entries allocated (tags 0..4); tag 2 was predicted TAKEN with recovery_target 0x20C; resolve tag 2 NOT_TAKEN.
  - Next cycle: o_redirect_valid=1, target 0x20C, tag 2.
  - o_count=3 and the next o_alloc_tag=3.
  - A later resolve of tag 4 is ignored.
- **Wrap-around:** 20 alloc/resolve/commit cycles with occupancy around 3.
  - Tags wrap 7→0.
  - Feedback order and fields are preserved.
  - o_empty=1 at the end.
- **Flush priority:** i_flush coincident with alloc, resolve and commit.
  - o_count=0 next cycle.
  - No o_fb_valid or o_redirect_valid pulse.
  - o_alloc_tag=0.
- **Async reset mid-stream:** rst asserted between clock edges with 4 entries held.
  - All outputs reach reset values before the next edge.
  - With BRANCH_FB_STATS_EN defined, the counters read 0.

Source files
------------

// File: rtl/mips_core_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mips_core_pkg
//  Description : Shared branch-prediction types and branch feedback queue
//                sizing for the MIPS core front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_core_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int GHIST_WIDTH = 8;

    // Branch feedback queue depth (power of two, >= 2)
    localparam int BFQ_DEPTH   = 8;

    typedef logic [$clog2(BFQ_DEPTH)-1:0] bfq_tag_t;

    typedef enum logic [0:0] {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    // Metadata captured by the branch controller at decode
    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [ADDR_WIDTH-1:0]  recovery_target;
        logic [GHIST_WIDTH-1:0] ghistory;
        BranchOutcome           prediction;
        BranchOutcome           gshare_prediction;
        BranchOutcome           twobit_prediction;
    } branch_pred_storage;

endpackage
`default_nettype wire

// File: rtl/branch_fb_stats.sv
`default_nettype none
// ============================================================================
//  Module      : branch_fb_stats
//  Description : Four 32-bit saturating counters sampled on every feedback
//                pulse: commits, mispredicts, gshare hits, two-bit hits.
//                Only instantiated when BRANCH_FB_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_fb_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_fb_valid,
    input  logic        i_mispredict,
    input  logic        i_gshare_correct,
    input  logic        i_twobit_correct,
    output logic [31:0] o_stat_commits,
    output logic [31:0] o_stat_mispredicts,
    output logic [31:0] o_stat_gshare_correct,
    output logic [31:0] o_stat_twobit_correct
);

    localparam logic [31:0] c_sat = 32'hFFFF_FFFF;

    logic [31:0] r_commits;
    logic [31:0] r_mispredicts;
    logic [31:0] r_gshare_correct;
    logic [31:0] r_twobit_correct;

    // Count each feedback pulse; counters stick at all-ones
    always_ff @(posedge clk or posedge rst) begin : p_counters
        if (rst) begin
            r_commits        <= '0;
            r_mispredicts    <= '0;
            r_gshare_correct <= '0;
            r_twobit_correct <= '0;
        end else if (i_fb_valid) begin
            if (r_commits != c_sat)
                r_commits <= r_commits + 32'd1;
            if (i_mispredict && (r_mispredicts != c_sat))
                r_mispredicts <= r_mispredicts + 32'd1;
            if (i_gshare_correct && (r_gshare_correct != c_sat))
                r_gshare_correct <= r_gshare_correct + 32'd1;
            if (i_twobit_correct && (r_twobit_correct != c_sat))
                r_twobit_correct <= r_twobit_correct + 32'd1;
        end
    end

    assign o_stat_commits        = r_commits;
    assign o_stat_mispredicts    = r_mispredicts;
    assign o_stat_gshare_correct = r_gshare_correct;
    assign o_stat_twobit_correct = r_twobit_correct;

endmodule
`default_nettype wire

// File: rtl/branch_feedback_queue.sv
`default_nettype none
// ============================================================================
//  Module      : branch_feedback_queue
//  Description : In-order queue of branch prediction metadata, allocated at
//                decode, resolved out of order by tag, committed in order.
//                Issues a registered redirect on mispredict and registered
//                feedback to the tournament predictor on commit.
//                Optional macro BRANCH_FB_STATS_EN adds o_stat_* counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_feedback_queue
    import mips_core_pkg::*;
#(
    parameter int DEPTH = BFQ_DEPTH,
    parameter int TAG_W = $clog2(DEPTH)
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_alloc_valid,
    input  branch_pred_storage    i_alloc_entry,
    output logic                  o_alloc_ready,
    output logic [TAG_W-1:0]      o_alloc_tag,
    input  logic                  i_resolve_valid,
    input  logic [TAG_W-1:0]      i_resolve_tag,
    input  BranchOutcome          i_resolve_outcome,
    output logic                  o_redirect_valid,
    output logic [ADDR_WIDTH-1:0] o_redirect_target,
    output logic [TAG_W-1:0]      o_redirect_tag,
    input  logic                  i_commit_valid,
    output logic                  o_commit_ready,
    input  logic                  i_flush,
    output logic                  o_fb_valid,
    output branch_pred_storage    o_fb_entry,
    output BranchOutcome          o_fb_outcome,
    output logic [TAG_W:0]        o_count,
    output logic                  o_empty
`ifdef BRANCH_FB_STATS_EN
    ,
    output logic [31:0]           o_stat_commits,
    output logic [31:0]           o_stat_mispredicts,
    output logic [31:0]           o_stat_gshare_correct,
    output logic [31:0]           o_stat_twobit_correct
`endif
);

    localparam logic [TAG_W:0] c_ptr_one = {{TAG_W{1'b0}}, 1'b1};

    // Pointers carry an extra wrap bit above the index
    logic [TAG_W:0]           r_head;
    logic [TAG_W:0]           r_tail;
    logic [DEPTH-1:0]         r_valid;
    logic [DEPTH-1:0]         r_resolved;
    BranchOutcome             r_outcome [DEPTH];
    branch_pred_storage       r_entry   [DEPTH];

    logic                     r_redirect_valid;
    logic [ADDR_WIDTH-1:0]    r_redirect_target;
    logic [TAG_W-1:0]         r_redirect_tag;
    logic                     r_fb_valid;
    branch_pred_storage       r_fb_entry;
    BranchOutcome             r_fb_outcome;

    logic [TAG_W-1:0]         w_head_idx;
    logic [TAG_W-1:0]         w_tail_idx;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_alloc_fire;
    logic                     w_commit_fire;
    logic                     w_resolve_ok;
    logic                     w_mispredict;
    logic [TAG_W-1:0]         w_res_off;
    logic [TAG_W:0]           w_squash_tail;
    logic [DEPTH-1:0]         w_kill;

    assign w_head_idx    = r_head[TAG_W-1:0];
    assign w_tail_idx    = r_tail[TAG_W-1:0];
    assign w_empty       = (r_head == r_tail);
    assign w_full        = (w_head_idx == w_tail_idx) && (r_head[TAG_W] != r_tail[TAG_W]);

    assign o_alloc_ready  = !w_full;
    assign o_alloc_tag    = w_tail_idx;
    assign o_commit_ready = r_valid[w_head_idx] && r_resolved[w_head_idx];
    assign o_count        = r_tail - r_head;
    assign o_empty        = w_empty;

    assign w_alloc_fire  = i_alloc_valid && !w_full;
    assign w_commit_fire = i_commit_valid && o_commit_ready;
    assign w_resolve_ok  = i_resolve_valid && r_valid[i_resolve_tag] && !r_resolved[i_resolve_tag];
    assign w_mispredict  = w_resolve_ok && (i_resolve_outcome != r_entry[i_resolve_tag].prediction);

    // Age of the resolved entry relative to head; the new tail sits just past it
    assign w_res_off     = i_resolve_tag - w_head_idx;
    assign w_squash_tail = r_head + {1'b0, w_res_off} + c_ptr_one;

    // Mark every entry younger than a mispredicted branch for squash
    always_comb begin : p_kill_mask
        w_kill = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_mispredict && ((TAG_W'(i) - w_head_idx) > w_res_off))
                w_kill[i] = 1'b1;
        end
    end

    // Queue pointers and per-entry state; flush overrides all same-cycle events
    always_ff @(posedge clk or posedge rst) begin : p_queue_state
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_valid    <= '0;
            r_resolved <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_outcome[i] <= NOT_TAKEN;
                r_entry[i]   <= '0;
            end
        end else if (i_flush) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_valid    <= '0;
            r_resolved <= '0;
        end else begin
            if (w_commit_fire) begin
                r_valid[w_head_idx] <= 1'b0;
                r_head              <= r_head + c_ptr_one;
            end
            if (w_resolve_ok) begin
                r_resolved[i_resolve_tag] <= 1'b1;
                r_outcome[i_resolve_tag]  <= i_resolve_outcome;
            end
            // A mispredict squashes the wrong path, including this cycle's alloc
            if (w_mispredict) begin
                r_tail <= w_squash_tail;
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_kill[i])
                        r_valid[i] <= 1'b0;
                end
            end else if (w_alloc_fire) begin
                r_valid[w_tail_idx]    <= 1'b1;
                r_resolved[w_tail_idx] <= 1'b0;
                r_entry[w_tail_idx]    <= i_alloc_entry;
                r_tail                 <= r_tail + c_ptr_one;
            end
        end
    end

    // Registered redirect and feedback pulses; payloads hold between pulses
    always_ff @(posedge clk or posedge rst) begin : p_outputs
        if (rst) begin
            r_redirect_valid  <= 1'b0;
            r_redirect_target <= '0;
            r_redirect_tag    <= '0;
            r_fb_valid        <= 1'b0;
            r_fb_entry        <= '0;
            r_fb_outcome      <= NOT_TAKEN;
        end else if (i_flush) begin
            r_redirect_valid  <= 1'b0;
            r_fb_valid        <= 1'b0;
        end else begin
            r_redirect_valid <= w_mispredict;
            if (w_mispredict) begin
                r_redirect_target <= r_entry[i_resolve_tag].recovery_target;
                r_redirect_tag    <= i_resolve_tag;
            end
            r_fb_valid <= w_commit_fire;
            if (w_commit_fire) begin
                r_fb_entry   <= r_entry[w_head_idx];
                r_fb_outcome <= r_outcome[w_head_idx];
            end
        end
    end

    assign o_redirect_valid  = r_redirect_valid;
    assign o_redirect_target = r_redirect_target;
    assign o_redirect_tag    = r_redirect_tag;
    assign o_fb_valid        = r_fb_valid;
    assign o_fb_entry        = r_fb_entry;
    assign o_fb_outcome      = r_fb_outcome;

`ifdef BRANCH_FB_STATS_EN
    logic w_stat_mispredict;
    logic w_stat_gshare_ok;
    logic w_stat_twobit_ok;

    assign w_stat_mispredict = (r_fb_entry.prediction != r_fb_outcome);
    assign w_stat_gshare_ok  = (r_fb_entry.gshare_prediction == r_fb_outcome);
    assign w_stat_twobit_ok  = (r_fb_entry.twobit_prediction == r_fb_outcome);

    branch_fb_stats u_stats (
        .clk                   (clk),
        .rst                   (rst),
        .i_fb_valid            (r_fb_valid),
        .i_mispredict          (w_stat_mispredict),
        .i_gshare_correct      (w_stat_gshare_ok),
        .i_twobit_correct      (w_stat_twobit_ok),
        .o_stat_commits        (o_stat_commits),
        .o_stat_mispredicts    (o_stat_mispredicts),
        .o_stat_gshare_correct (o_stat_gshare_correct),
        .o_stat_twobit_correct (o_stat_twobit_correct)
    );
`endif

`ifndef SYNTHESIS
    // Committing a branch that is not at a resolved head is a protocol error
    a_commit_when_ready: assert property (@(posedge clk) disable iff (rst)
        !(i_commit_valid && !o_commit_ready));
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_feedback_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_feedback_queue
//  Description : Self-checking bench for branch_feedback_queue. A queue-based
//                reference model tracks program order; a compare process
//                checks every DUT output each cycle, and directed scenarios
//                pin literal values. Honours BRANCH_FB_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_feedback_queue;
    import mips_core_pkg::*;

    localparam int DEPTH = BFQ_DEPTH;
    localparam int TAG_W = $clog2(DEPTH);

    logic                  clk;
    logic                  rst;
    logic                  i_alloc_valid;
    branch_pred_storage    i_alloc_entry;
    logic                  o_alloc_ready;
    logic [TAG_W-1:0]      o_alloc_tag;
    logic                  i_resolve_valid;
    logic [TAG_W-1:0]      i_resolve_tag;
    BranchOutcome          i_resolve_outcome;
    logic                  o_redirect_valid;
    logic [ADDR_WIDTH-1:0] o_redirect_target;
    logic [TAG_W-1:0]      o_redirect_tag;
    logic                  i_commit_valid;
    logic                  o_commit_ready;
    logic                  i_flush;
    logic                  o_fb_valid;
    branch_pred_storage    o_fb_entry;
    BranchOutcome          o_fb_outcome;
    logic [TAG_W:0]        o_count;
    logic                  o_empty;
`ifdef BRANCH_FB_STATS_EN
    logic [31:0] o_stat_commits, o_stat_mispredicts, o_stat_gshare_correct, o_stat_twobit_correct;
`endif

    branch_feedback_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_alloc_valid     (i_alloc_valid),
        .i_alloc_entry     (i_alloc_entry),
        .o_alloc_ready     (o_alloc_ready),
        .o_alloc_tag       (o_alloc_tag),
        .i_resolve_valid   (i_resolve_valid),
        .i_resolve_tag     (i_resolve_tag),
        .i_resolve_outcome (i_resolve_outcome),
        .o_redirect_valid  (o_redirect_valid),
        .o_redirect_target (o_redirect_target),
        .o_redirect_tag    (o_redirect_tag),
        .i_commit_valid    (i_commit_valid),
        .o_commit_ready    (o_commit_ready),
        .i_flush           (i_flush),
        .o_fb_valid        (o_fb_valid),
        .o_fb_entry        (o_fb_entry),
        .o_fb_outcome      (o_fb_outcome),
        .o_count           (o_count),
        .o_empty           (o_empty)
`ifdef BRANCH_FB_STATS_EN
        ,
        .o_stat_commits        (o_stat_commits),
        .o_stat_mispredicts    (o_stat_mispredicts),
        .o_stat_gshare_correct (o_stat_gshare_correct),
        .o_stat_twobit_correct (o_stat_twobit_correct)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    logic chk_en = 1'b0;

    // ---------------- reference model ----------------
    typedef struct {
        branch_pred_storage e;
        logic               resolved;
        BranchOutcome       outcome;
    } mrec_t;

    mrec_t              mq[$];
    int                 m_head = 0;
    int                 m_tail = 0;
    logic               exp_fb_valid = 1'b0;
    branch_pred_storage exp_fb_entry = '0;
    BranchOutcome       exp_fb_outcome = NOT_TAKEN;
    logic               exp_rd_valid = 1'b0;
    logic [31:0]        exp_rd_target = '0;
    int                 exp_rd_tag = 0;
    logic [31:0]        st_commits = '0, st_mis = '0, st_gs = '0, st_tb = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_head = 0; m_tail = 0;
        exp_fb_valid = 1'b0; exp_fb_entry = '0; exp_fb_outcome = NOT_TAKEN;
        exp_rd_valid = 1'b0; exp_rd_target = '0; exp_rd_tag = 0;
        st_commits = '0; st_mis = '0; st_gs = '0; st_tb = '0;
    endtask

    // Advance the model by one clock edge given this cycle's inputs
    task automatic model_step(input logic av, input branch_pred_storage ae, input logic rv,
                              input int rt, input BranchOutcome ro, input logic cv, input logic fl);
        int   k;
        logic commit, alloc, mis;
        mrec_t r;
        if (exp_fb_valid) begin
            st_commits = sat_inc(st_commits);
            if (exp_fb_entry.prediction != exp_fb_outcome)        st_mis = sat_inc(st_mis);
            if (exp_fb_entry.gshare_prediction == exp_fb_outcome) st_gs  = sat_inc(st_gs);
            if (exp_fb_entry.twobit_prediction == exp_fb_outcome) st_tb  = sat_inc(st_tb);
        end
        if (fl) begin
            mq.delete(); m_head = 0; m_tail = 0;
            exp_fb_valid = 1'b0; exp_rd_valid = 1'b0;
            return;
        end
        commit = cv && (mq.size() > 0) && mq[0].resolved;
        alloc  = av && (mq.size() < DEPTH);
        k = -1;
        if (rv)
            for (int j = 0; j < mq.size(); j++)
                if (((m_head + j) % DEPTH) == rt) k = j;
        mis = 1'b0;
        if (k >= 0 && !mq[k].resolved) begin
            mq[k].resolved = 1'b1;
            mq[k].outcome  = ro;
            mis = (ro != mq[k].e.prediction);
        end
        exp_rd_valid = mis;
        if (mis) begin
            exp_rd_target = mq[k].e.recovery_target;
            exp_rd_tag    = rt;
        end
        exp_fb_valid = commit;
        if (commit) begin
            exp_fb_entry   = mq[0].e;
            exp_fb_outcome = mq[0].outcome;
        end
        if (mis) begin
            while (mq.size() > k + 1) void'(mq.pop_back());
            m_tail = m_head + k + 1;
        end else if (alloc) begin
            r.e = ae; r.resolved = 1'b0; r.outcome = NOT_TAKEN;
            mq.push_back(r);
            m_tail++;
        end
        if (commit) begin
            void'(mq.pop_front());
            m_head++;
        end
    endtask

    // Compare every DUT output against the model once per cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("count",        128'(o_count),            128'(mq.size()));
            chk("empty",        128'(o_empty),            128'(mq.size() == 0));
            chk("alloc_ready",  128'(o_alloc_ready),      128'(mq.size() < DEPTH));
            chk("alloc_tag",    128'(o_alloc_tag),        128'(m_tail % DEPTH));
            chk("commit_ready", 128'(o_commit_ready),     128'((mq.size() > 0) ? mq[0].resolved : 1'b0));
            chk("fb_valid",     128'(o_fb_valid),         128'(exp_fb_valid));
            chk("fb_entry",     128'(o_fb_entry),         128'(exp_fb_entry));
            chk("fb_outcome",   128'(o_fb_outcome),       128'(exp_fb_outcome));
            chk("rd_valid",     128'(o_redirect_valid),   128'(exp_rd_valid));
            chk("rd_target",    128'(o_redirect_target),  128'(exp_rd_target));
            chk("rd_tag",       128'(o_redirect_tag),     128'(exp_rd_tag));
`ifdef BRANCH_FB_STATS_EN
            chk("stat_commits", 128'(o_stat_commits),        128'(st_commits));
            chk("stat_mis",     128'(o_stat_mispredicts),    128'(st_mis));
            chk("stat_gshare",  128'(o_stat_gshare_correct), 128'(st_gs));
            chk("stat_twobit",  128'(o_stat_twobit_correct), 128'(st_tb));
`endif
        end
    end

    function automatic branch_pred_storage mk(input logic [31:0] pc, input BranchOutcome pred,
                                              input logic [31:0] tgt);
        branch_pred_storage e;
        e.pc                = pc;
        e.recovery_target   = tgt;
        e.ghistory          = GHIST_WIDTH'($urandom);
        e.prediction        = pred;
        e.gshare_prediction = BranchOutcome'(1'($urandom));
        e.twobit_prediction = BranchOutcome'(1'($urandom));
        return e;
    endfunction

    // Apply one cycle of stimulus just after the falling edge
    task automatic drive(input logic av, input branch_pred_storage ae, input logic rv,
                         input int rt, input BranchOutcome ro, input logic cv, input logic fl);
        @(negedge clk); #1;
        i_alloc_valid     = av;
        i_alloc_entry     = ae;
        i_resolve_valid   = rv;
        i_resolve_tag     = TAG_W'(rt);
        i_resolve_outcome = ro;
        i_commit_valid    = cv;
        i_flush           = fl;
        model_step(av, ae, rv, rt, ro, cv, fl);
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 0, NOT_TAKEN, 1'b0, 1'b0);
    endtask

    function automatic int tag_of(input int j);
        return (m_head + j) % DEPTH;
    endfunction

    // Resolve the oldest unresolved entry correctly and commit the head if ready
    task automatic drain(input int budget);
        for (int n = 0; n < budget && mq.size() > 0; n++) begin
            int j = -1;
            for (int x = mq.size() - 1; x >= 0; x--) if (!mq[x].resolved) j = x;
            drive(1'b0, '0, (j >= 0), (j >= 0) ? tag_of(j) : 0,
                  (j >= 0) ? mq[j].e.prediction : NOT_TAKEN, mq[0].resolved, 1'b0);
        end
    endtask

    initial begin
        i_alloc_valid = 0; i_alloc_entry = '0; i_resolve_valid = 0; i_resolve_tag = '0;
        i_resolve_outcome = NOT_TAKEN; i_commit_valid = 0; i_flush = 0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // Fill and backpressure
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, mk(32'h100 + 32'(4 * i), TAKEN, 32'h500), 1'b0, 0, NOT_TAKEN, 1'b0, 1'b0);
            chk("fill_tag", 128'(o_alloc_tag), 128'(i));
        end
        idle();
        chk("full_ready", 128'(o_alloc_ready), 128'(0));
        chk("full_count", 128'(o_count), 128'(8));
        drive(1'b1, mk(32'h120, TAKEN, 32'h0), 1'b0, 0, NOT_TAKEN, 1'b0, 1'b0);
        idle();
        chk("ninth_ignored", 128'(o_count), 128'(8));

        // In-order feedback after out-of-order resolve
        drive(1'b0, '0, 1'b1, 2, TAKEN, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 0, TAKEN, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1, TAKEN, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, 1'b0, 0, NOT_TAKEN, 1'b1, 1'b0);
            idle();
            chk("fb_pulse", 128'(o_fb_valid), 128'(1));
            chk("fb_pc", 128'(o_fb_entry.pc), 128'(32'h100 + 32'(4 * k)));
        end
        drain(40);

        // Mispredict squash: queue is empty with head index 0
        for (int i = 0; i < 5; i++)
            drive(1'b1, (i == 2) ? mk(32'h200 + 32'(4 * i), TAKEN, 32'h20C)
                                 : mk(32'h200 + 32'(4 * i), BranchOutcome'(1'($urandom)), 32'h600),
                  1'b0, 0, NOT_TAKEN, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 2, NOT_TAKEN, 1'b0, 1'b0);
        idle();
        chk("mis_rd_valid", 128'(o_redirect_valid), 128'(1));
        chk("mis_rd_target", 128'(o_redirect_target), 128'(32'h20C));
        chk("mis_rd_tag", 128'(o_redirect_tag), 128'(2));
        chk("mis_count", 128'(o_count), 128'(3));
        chk("mis_alloc_tag", 128'(o_alloc_tag), 128'(3));
        drive(1'b0, '0, 1'b1, 4, BranchOutcome'(1'($urandom)), 1'b0, 1'b0);
        idle();
        chk("squashed_resolve", 128'(o_redirect_valid), 128'(0));
        chk("squashed_count", 128'(o_count), 128'(3));
        drain(40);

        // Wrap-around at occupancy around 3
        for (int n = 0; n < 20; n++) begin
            int j = -1;
            for (int x = mq.size() - 1; x >= 0; x--) if (!mq[x].resolved) j = x;
            drive(mq.size() < 3, mk(32'h300 + 32'(4 * n), BranchOutcome'(1'($urandom)), 32'h700),
                  (j >= 0), (j >= 0) ? tag_of(j) : 0, (j >= 0) ? mq[j].e.prediction : NOT_TAKEN,
                  (mq.size() > 0) && mq[0].resolved, 1'b0);
        end
        drain(40);
        idle();
        chk("wrap_empty", 128'(o_empty), 128'(1));

        // Flush coincident with alloc, mispredicting resolve and commit
        for (int i = 0; i < 4; i++)
            drive(1'b1, mk(32'h400 + 32'(4 * i), TAKEN, 32'h800), 1'b0, 0, NOT_TAKEN, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, tag_of(0), TAKEN, 1'b0, 1'b0);
        drive(1'b1, mk(32'h410, TAKEN, 32'h0), 1'b1, tag_of(1), NOT_TAKEN, 1'b1, 1'b1);
        idle();
        chk("flush_count", 128'(o_count), 128'(0));
        chk("flush_fb", 128'(o_fb_valid), 128'(0));
        chk("flush_rd", 128'(o_redirect_valid), 128'(0));
        chk("flush_tag", 128'(o_alloc_tag), 128'(0));

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic av, rv, cv, fl;
            int   rt;
            av = ($urandom_range(0, 9) < 6);
            rv = ($urandom_range(0, 9) < 5);
            if (mq.size() > 0 && $urandom_range(0, 9) < 8) rt = tag_of($urandom_range(0, mq.size() - 1));
            else rt = $urandom_range(0, DEPTH - 1);
            cv = (mq.size() > 0) && mq[0].resolved && ($urandom_range(0, 1) == 1);
            fl = ($urandom_range(0, 99) < 2);
            drive(av, mk($urandom, BranchOutcome'(1'($urandom)), $urandom), rv, rt,
                  BranchOutcome'(1'($urandom)), cv, fl);
        end
        drain(60);

        // Asynchronous reset with four entries held and a feedback pulse live
        for (int i = 0; i < 5; i++)
            drive(1'b1, mk(32'h900 + 32'(4 * i), TAKEN, 32'hA00), 1'b0, 0, NOT_TAKEN, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, tag_of(0), TAKEN, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 0, NOT_TAKEN, 1'b1, 1'b0);
        idle();
        chk("pre_rst_count", 128'(o_count), 128'(4));
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_alloc_ready", 128'(o_alloc_ready), 128'(1));
        chk("rst_alloc_tag", 128'(o_alloc_tag), 128'(0));
        chk("rst_rd_valid", 128'(o_redirect_valid), 128'(0));
        chk("rst_rd_target", 128'(o_redirect_target), 128'(0));
        chk("rst_rd_tag", 128'(o_redirect_tag), 128'(0));
        chk("rst_commit_ready", 128'(o_commit_ready), 128'(0));
        chk("rst_fb_valid", 128'(o_fb_valid), 128'(0));
        chk("rst_fb_entry", 128'(o_fb_entry), 128'(0));
        chk("rst_fb_outcome", 128'(o_fb_outcome), 128'(NOT_TAKEN));
        chk("rst_count", 128'(o_count), 128'(0));
        chk("rst_empty", 128'(o_empty), 128'(1));
`ifdef BRANCH_FB_STATS_EN
        chk("rst_stat_commits", 128'(o_stat_commits), 128'(0));
        chk("rst_stat_mis", 128'(o_stat_mispredicts), 128'(0));
        chk("rst_stat_gshare", 128'(o_stat_gshare_correct), 128'(0));
        chk("rst_stat_twobit", 128'(o_stat_twobit_correct), 128'(0));
`endif
        i_alloc_valid = 0; i_resolve_valid = 0; i_commit_valid = 0; i_flush = 0;
        @(negedge clk); #1 rst = 1'b0;
        idle();
        idle();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
